mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Sequential accumulation stage directly downstream of the 16x16 array multiplier. It consumes one 33-bit unsigned product per accepted beat and sums a packet of products, delimited by `in_last` or by a term limit, into a saturating accumulator. It presents the packet total on a valid/ready output, forming the multiply-accumulate / dot-product datapath.

## Interface
- `ACC_W`, 40: accumulator and result width; must be ≥ 33.
- `MAX_TERMS`, 256: maximum products per packet; the term that reaches this count closes the packet.
- `CNT_W`, 16: width of the term counter; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous abort of the current packet.
- `in_product`  in  33  unsigned product from the multiplier (`c[32:0]`).
- `in_valid`  in  1  product beat valid.
- `in_last`  in  1  beat is the final term of the packet.
- `in_ready`  out  1  block can accept a beat.
- `out_result`  out  ACC_W  packet sum.
- `out_count`  out  CNT_W  number of terms in the packet.
- `out_ovf`  out  1  packet saturated.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- States: IDLE, ACCUM, HOLD.
- Accept condition: `in_valid && in_ready`. `in_ready` = 1 in IDLE and ACCUM, 0 in HOLD.
- **IDLE, accept:**
  - acc ← zero-extended product; count ← 1; ovf ← 0.
  - Go to HOLD if the beat is last, otherwise go to ACCUM.
- **ACCUM, accept:**
  - acc ← sat(acc + product); count ← count + 1; ovf ← ovf | carry.
- A beat is "last" when `in_last` is set or the new count equals MAX_TERMS.
- **Last beat:**
  - `out_result`, `out_count` and `out_ovf` are loaded from the updated values.
  - `out_valid` ← 1; state ← HOLD.
- **Saturation:** unsigned. A carry out of bit ACC_W-1 forces acc to all ones and sets the sticky ovf for the rest of the packet.
- **HOLD:**
  - Outputs are stable while `out_valid && !out_ready`.
  - On `out_ready`: `out_valid` ← 0 and state ← IDLE.
- **`clr`:**
  - From any state, go to IDLE; acc, count, ovf ← 0; `out_valid` ← 0.
  - A pending result is discarded.
  - A beat presented in the same cycle as `clr` is not consumed, and `in_ready` is ignored for that cycle.
- **Priority:** `rst` > `clr` > handshakes.
- **Reset values:** state IDLE, `in_ready` 1, `out_valid` 0, `out_result` 0, `out_count` 0, `out_ovf` 0, internal acc/count 0.
- `in_product[32]` is added as data. The multiplier drives it 0, but it is not masked.

## Timing
- Input acceptance has no bubbles. In ACCUM, one beat per cycle is accepted indefinitely until last.
- Last beat accepted at edge N → `out_valid` = 1 after edge N.
- `in_ready` = 0 from edge N until the edge where `out_ready` is sampled high.
- `in_ready` returns to 1 one cycle after the output handshake. There is no same-cycle bypass of the next packet.
- Minimum packet period is 2 cycles: a single-term packet followed by a handshake in the next cycle.
- `rst` or `clr` asserted mid-packet takes effect at that edge. The next accepted beat starts a new packet from zero.
- `in_ready` and `out_valid` are registered. They have no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `mac_pkg` holds:
  - the state enum (IDLE/ACCUM/HOLD);
  - the default ACC_W, MAX_TERMS and CNT_W constants;
  - the product width constant PROD_W = 33.
- One natural sub-module, `sat_adder`: ACC_W-bit unsigned add with saturate and carry-flag output, instantiated once for the accumulator update.
- The multiplier itself stays a separate instance outside this block.

## Test plan
- Reset mid-ACCUM with 3 beats summed → all outputs 0 and `in_ready`=1 on the next cycle; a new single beat of 5 with last → result 5, count 1.
- Products 0xFFFE0001 ×4, last on 4th → result 0x3FFF80004, count 4, ovf 0, `out_valid` one cycle after the last beat.
- ACC_W=33, two beats of 0x1FFFFFFFF → result 0x1FFFFFFFF, ovf 1; ovf remains set after a further beat of 0.
- MAX_TERMS=4, 6 beats of 1 with `in_last` never set → first result 4/count 4; `in_ready` low until `out_ready`; second packet accumulates the remaining 2 beats.
- `out_ready` held low 5 cycles in HOLD with `in_valid` high → no beat consumed, outputs stable; `out_ready` pulse → `in_ready`=1 the next cycle, then the beat is accepted.
- `clr` asserted in HOLD with `in_valid` high → `out_valid` drops, result discarded, that beat not consumed; the next cycle's beat of 7 with last → result 7.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizing for the multiply-accumulate stage.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int PROD_W        = 33;
    localparam int ACC_W_DEF     = 40;
    localparam int MAX_TERMS_DEF = 256;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit adder that clamps to all ones on carry-out; combinational.
module sat_adder #(
    parameter int W = 40
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);

    logic [W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[W];
    assign o_sum   = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/mac_accumulator.sv
// Sums a packet of multiplier products into a saturating accumulator; result valid the cycle after the last beat.
// Input is stalled (in_ready low) while a result waits for out_ready; all handshake outputs are registered.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_result,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_result;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_first;
    logic               w_accept;
    logic               w_last;
    logic               w_carry;
    logic               w_new_ovf;
    logic [ACC_W-1:0]   w_add_a;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_new_cnt;

    // The first beat of a packet adds onto zero, so one adder covers both load and accumulate.
    assign w_first    = (r_state == ST_IDLE);
    assign w_add_a    = w_first ? '0 : r_acc;
    assign w_prod_ext = ACC_W'(in_product);
    assign w_new_cnt  = w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_new_ovf  = (!w_first && r_ovf) || w_carry;
    assign w_last     = in_last || (w_new_cnt == CNT_W'(MAX_TERMS));
    assign w_accept   = in_valid && r_in_ready;

    sat_adder #(
        .W (ACC_W)
    ) u_sat_adder (
        .i_a     (w_add_a),
        .i_b     (w_prod_ext),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_count  <= '0;
            r_out_ovf    <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= w_new_cnt;
                        r_ovf <= w_new_ovf;
                        if (w_last) begin
                            r_out_result <= w_sum;
                            r_out_count  <= w_new_cnt;
                            r_out_ovf    <= w_new_ovf;
                            r_out_valid  <= 1'b1;
                            r_in_ready   <= 1'b0;
                            r_state      <= ST_HOLD;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_count  = r_out_count;
    assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboarded bench: instance 0 at default sizing, instance 1 with ACC_W=33 / MAX_TERMS=4.
`timescale 1ns/1ps
module tb_mac_accumulator;

    typedef struct {
        longint res;
        int     cnt;
        bit     ovf;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        clr  [2];
    logic        vld  [2];
    logic        lst  [2];
    logic        ordy [2];
    logic        rdy  [2];
    logic        ovld [2];
    logic        ovf  [2];
    logic [32:0] prod [2];
    logic [15:0] cnt  [2];
    logic [39:0] d_res;
    logic [32:0] s_res;

    mac_accumulator u_d (
        .clk        (clk),
        .rst        (rst[0]),
        .clr        (clr[0]),
        .in_product (prod[0]),
        .in_valid   (vld[0]),
        .in_last    (lst[0]),
        .in_ready   (rdy[0]),
        .out_result (d_res),
        .out_count  (cnt[0]),
        .out_ovf    (ovf[0]),
        .out_valid  (ovld[0]),
        .out_ready  (ordy[0])
    );

    mac_accumulator #(
        .ACC_W     (33),
        .MAX_TERMS (4),
        .CNT_W     (16)
    ) u_s (
        .clk        (clk),
        .rst        (rst[1]),
        .clr        (clr[1]),
        .in_product (prod[1]),
        .in_valid   (vld[1]),
        .in_last    (lst[1]),
        .in_ready   (rdy[1]),
        .out_result (s_res),
        .out_count  (cnt[1]),
        .out_ovf    (ovf[1]),
        .out_valid  (ovld[1]),
        .out_ready  (ordy[1])
    );

    int     n_pass  = 0;
    int     n_total = 0;
    exp_t   q0[$];
    exp_t   q1[$];
    longint m_sum [2];
    int     m_n   [2];
    bit     rand_en = 1'b0;

    function automatic void chk(string nm, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endfunction

    function automatic longint res_of(int k);
        return (k == 0) ? longint'(d_res) : longint'(s_res);
    endfunction

    function automatic longint maxv(int k);
        return (k == 0) ? ((64'd1 << 40) - 1) : ((64'd1 << 33) - 1);
    endfunction

    function automatic int maxt(int k);
        return (k == 0) ? 256 : 4;
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push(int k, exp_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic exp_t qpop(int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void model_reset(int k);
        if (k == 0) q0.delete();
        else q1.delete();
        m_sum[k] = 0;
        m_n[k]   = 0;
    endfunction

    // Reference: a packet's result is its plain arithmetic sum clamped to the accumulator range.
    task automatic beat(input int k, input logic [32:0] p, input bit last, input int idle);
        int   waited;
        exp_t e;
        repeat (idle) begin
            @(posedge clk); #1;
        end
        vld[k]  = 1'b1;
        prod[k] = p;
        lst[k]  = last;
        @(negedge clk);
        waited = 0;
        while (!rdy[k] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[k]) begin
            chk("accept_timeout", 0, 1);
            vld[k] = 1'b0;
            lst[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        m_sum[k] += longint'(p);
        m_n[k]++;
        if (last || m_n[k] == maxt(k)) begin
            e.res = (m_sum[k] > maxv(k)) ? maxv(k) : m_sum[k];
            e.cnt = m_n[k];
            e.ovf = (m_sum[k] > maxv(k));
            push(k, e);
            chk("valid_after_last", longint'(ovld[k]), 1);
            chk("ready_low_in_hold", longint'(rdy[k]), 0);
            m_sum[k] = 0;
            m_n[k]   = 0;
        end else begin
            chk("ready_no_bubble", longint'(rdy[k]), 1);
            chk("valid_low_accum", longint'(ovld[k]), 0);
        end
        vld[k] = 1'b0;
        lst[k] = 1'b0;
    endtask

    task automatic do_rst(input int k);
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        model_reset(k);
    endtask

    task automatic chk_zero(input int k);
        chk("rst_result", res_of(k), 0);
        chk("rst_count", longint'(cnt[k]), 0);
        chk("rst_ovf", longint'(ovf[k]), 0);
        chk("rst_out_valid", longint'(ovld[k]), 0);
        chk("rst_in_ready", longint'(rdy[k]), 1);
    endtask

    task automatic drain(input int k);
        int w;
        if (k == 0) rand_en = 1'b0;
        ordy[k] = 1'b1;
        w = 0;
        while (qsize(k) != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_queue_empty", qsize(k), 0);
    endtask

    // Monitor: pops on every output handshake and checks stability while stalled.
    bit         hold_prev [2];
    longint     sv_res    [2];
    longint     sv_cnt    [2];
    longint     sv_ovf    [2];
    initial begin
        hold_prev[0] = 1'b0;
        hold_prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ovld[k] === 1'b1) begin
                    if (hold_prev[k]) begin
                        chk("stable_result", res_of(k), sv_res[k]);
                        chk("stable_count", longint'(cnt[k]), sv_cnt[k]);
                        chk("stable_ovf", longint'(ovf[k]), sv_ovf[k]);
                    end
                    if (ordy[k] === 1'b1) begin
                        if (qsize(k) == 0) begin
                            chk("unexpected_result", 1, 0);
                        end else begin
                            exp_t e;
                            e = qpop(k);
                            chk("result", res_of(k), e.res);
                            chk("count", longint'(cnt[k]), longint'(e.cnt));
                            chk("ovf", longint'(ovf[k]), longint'(e.ovf));
                        end
                        hold_prev[k] = 1'b0;
                    end else begin
                        hold_prev[k] = 1'b1;
                        sv_res[k]    = res_of(k);
                        sv_cnt[k]    = longint'(cnt[k]);
                        sv_ovf[k]    = longint'(ovf[k]);
                    end
                end else begin
                    hold_prev[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_en) ordy[0] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; clr[k] = 1'b0; vld[k] = 1'b0; lst[k] = 1'b0;
            ordy[k] = 1'b0; prod[k] = '0;
            m_sum[k] = 0; m_n[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_zero(0);
        chk_zero(1);

        // Reset mid-packet, then a single-term packet starts from zero.
        ordy[0] = 1'b1;
        beat(0, 33'd1, 1'b0, 0);
        beat(0, 33'd2, 1'b0, 0);
        beat(0, 33'd3, 1'b0, 0);
        do_rst(0);
        chk_zero(0);
        beat(0, 33'd5, 1'b1, 0);
        drain(0);

        for (int i = 0; i < 4; i++) beat(0, 33'hFFFE0001, i == 3, 0);
        drain(0);

        // Stall in HOLD with a beat waiting, then release with a one-cycle out_ready pulse.
        ordy[0] = 1'b0;
        beat(0, 33'd9, 1'b1, 0);
        vld[0] = 1'b1; prod[0] = 33'd11; lst[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", longint'(ovld[0]), 1);
            chk("hold_in_ready", longint'(rdy[0]), 0);
            chk("hold_result", res_of(0), 9);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("ready_after_handshake", longint'(rdy[0]), 1);
        chk("valid_after_handshake", longint'(ovld[0]), 0);
        beat(0, 33'd11, 1'b1, 0);
        drain(0);

        // Abort a pending result; the beat presented alongside clr must not be taken.
        ordy[0] = 1'b0;
        beat(0, 33'd3, 1'b1, 0);
        vld[0] = 1'b1; prod[0] = 33'd100; lst[0] = 1'b1;
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        model_reset(0);
        chk("clr_valid", longint'(ovld[0]), 0);
        chk("clr_in_ready", longint'(rdy[0]), 1);
        beat(0, 33'd7, 1'b1, 0);
        drain(0);

        // Saturation at ACC_W=33 stays sticky through a further zero term.
        ordy[1] = 1'b1;
        beat(1, 33'h1FFFFFFFF, 1'b0, 0);
        beat(1, 33'h1FFFFFFFF, 1'b0, 0);
        beat(1, 33'd0, 1'b1, 0);
        drain(1);

        // Term limit of 4 closes the packet without in_last.
        ordy[1] = 1'b0;
        for (int i = 0; i < 4; i++) beat(1, 33'd1, 1'b0, 0);
        vld[1] = 1'b1; prod[1] = 33'd1; lst[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("limit_in_ready_low", longint'(rdy[1]), 0);
        end
        @(posedge clk); #1;
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        beat(1, 33'd1, 1'b0, 0);
        beat(1, 33'd1, 1'b1, 0);
        drain(1);

        // Randomized packets with random consumer backpressure.
        rand_en = 1'b1;
        for (int pk = 0; pk < 40; pk++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                logic [32:0] p;
                if ($urandom_range(0, 3) == 0) p = {1'($urandom), 32'($urandom)};
                else p = 33'($urandom_range(0, 1000));
                beat(0, p, i == len - 1, $urandom_range(0, 2));
            end
        end
        for (int i = 0; i < 256; i++) beat(0, 33'h1FFFFFFFF, 1'b0, 0);
        drain(0);

        ordy[1] = 1'b1;
        for (int pk = 0; pk < 20; pk++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                logic [32:0] p;
                p = {1'($urandom), 32'($urandom)};
                beat(1, p, i == len - 1, $urandom_range(0, 1));
            end
        end
        drain(1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
